// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared state type, accumulator limits and saturating add for the PE
package pe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_state_e;

    // Helpers work at this width; narrower accumulators scale the limits down.
    localparam int SAT_W = 64;

    localparam logic signed [SAT_W-1:0] ACC_MAX = {1'b0, {(SAT_W-1){1'b1}}};
    localparam logic signed [SAT_W-1:0] ACC_MIN = {1'b1, {(SAT_W-1){1'b0}}};

    // Returns {clamped_sum, overflow} for a w-bit signed accumulator.
    function automatic logic [SAT_W:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi = {1'b0, ACC_MAX >>> (SAT_W - w)};
        lo = {1'b1, ACC_MIN >>> (SAT_W - w)};
        if (s > hi) begin
            sat_add = {hi[SAT_W-1:0], 1'b1};
        end else if (s < lo) begin
            sat_add = {lo[SAT_W-1:0], 1'b1};
        end else begin
            sat_add = {s[SAT_W-1:0], 1'b0};
        end
    endfunction

endpackage

// File: rtl/pe_sat_adder.sv
// rtl/pe_sat_adder.sv - combinational accumulate adder, saturating or wrapping
module pe_sat_adder
    import pe_pkg::*;
#(
    parameter int ACC_WIDTH = 40,
    parameter bit SATURATE  = 1'b1
) (
    input  logic signed [ACC_WIDTH-1:0] i_a,
    input  logic signed [ACC_WIDTH-1:0] i_b,
    output logic signed [ACC_WIDTH-1:0] o_sum,
    output logic                        o_ovf
);

    if (SATURATE) begin : g_sat
        logic signed [SAT_W-1:0]       w_a_ext;
        logic signed [SAT_W-1:0]       w_b_ext;
        logic [SAT_W:0]                w_sat;
        logic [SAT_W-ACC_WIDTH:0]      w_unused_hi;

        assign w_a_ext     = SAT_W'(i_a);
        assign w_b_ext     = SAT_W'(i_b);
        assign w_sat       = sat_add(w_a_ext, w_b_ext, ACC_WIDTH);
        assign o_sum       = w_sat[ACC_WIDTH:1];
        assign o_ovf       = w_sat[0];
        // Clamped result already fits ACC_WIDTH; the upper bits are pure sign extension.
        assign w_unused_hi = w_sat[SAT_W:ACC_WIDTH];
    end else begin : g_wrap
        assign o_sum = i_a + i_b;
        assign o_ovf = 1'b0;
    end

endmodule

// File: rtl/pe_os_mac.sv
// rtl/pe_os_mac.sv - output-stationary systolic MAC PE with held result and drain chain
module pe_os_mac
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic                  a_valid_in,
    input  logic                  a_last_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  b_valid_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_valid_out,
    output logic                  a_last_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  b_valid_out,
    input  logic                  drain_en,
    input  logic [ACC_WIDTH-1:0]  drain_in,
    input  logic                  drain_valid_in,
    output logic [ACC_WIDTH-1:0]  drain_out,
    output logic                  drain_valid_out,
    output logic                  res_pending,
    output logic                  sat_flag,
    output logic                  overrun_flag
);

    if (ACC_WIDTH < 2 * DATA_WIDTH || ACC_WIDTH > SAT_W) begin : g_bad_width
        $error("pe_os_mac: ACC_WIDTH must be within [2*DATA_WIDTH, 64]");
    end

    pe_state_e                      r_state;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    r_res;
    logic                           r_res_valid;

    logic                           w_fire;
    logic                           w_capture;
    logic                           w_emit;
    logic                           w_ovf;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_base;
    logic signed [ACC_WIDTH-1:0]    w_sum;

    assign w_fire     = a_valid_in & b_valid_in;
    assign w_capture  = w_fire & a_last_in;
    assign w_emit     = drain_en & r_res_valid;
    assign w_prod     = $signed(a_in) * $signed(b_in);
    assign w_prod_ext = ACC_WIDTH'(w_prod);
    assign w_base     = (r_state == ACCUM) ? r_acc : '0;
    assign res_pending = r_res_valid;

    pe_sat_adder #(
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_add (
        .i_a   (w_base),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // Operand pipes ignore clr so a soft clear never starves downstream PEs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
            a_last_out  <= 1'b0;
            b_out       <= '0;
            b_valid_out <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
            a_last_out  <= a_last_in;
            b_out       <= b_in;
            b_valid_out <= b_valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state         <= IDLE;
            r_acc           <= '0;
            r_res           <= '0;
            r_res_valid     <= 1'b0;
            drain_out       <= '0;
            drain_valid_out <= 1'b0;
            sat_flag        <= 1'b0;
            overrun_flag    <= 1'b0;
        end else begin
            if (w_fire) begin
                if (w_ovf) begin
                    sat_flag <= 1'b1;
                end
                if (a_last_in) begin
                    r_res   <= w_sum;
                    r_acc   <= '0;
                    r_state <= IDLE;
                end else begin
                    r_acc   <= w_sum;
                    r_state <= ACCUM;
                end
            end

            // A capture in the same cycle as an emission keeps res_valid high.
            if (w_capture) begin
                r_res_valid <= 1'b1;
                if (r_res_valid && !w_emit) begin
                    overrun_flag <= 1'b1;
                end
            end else if (w_emit) begin
                r_res_valid <= 1'b0;
            end

            if (drain_en) begin
                if (r_res_valid) begin
                    drain_out       <= r_res;
                    drain_valid_out <= 1'b1;
                end else begin
                    drain_out       <= drain_in;
                    drain_valid_out <= drain_valid_in;
                end
            end else begin
                drain_valid_out <= 1'b0;
            end
        end
    end

endmodule
